// File: rtl/sto_cp_remover.sv
// sto_cp_remover: buffers the received sample stream from frame start (go), waits for the
// STO estimate, then strips the cyclic prefix and emits NSYM symbols of Nfft samples each,
// starting at absolute sample index est_STO + Ng. Output is registered, one cycle after issue.
module sto_cp_remover #(
  parameter int DW   = 16,
  parameter int AW   = 10,
  parameter int IW   = 16,
  parameter int NSYM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic [11:0]   Ng,
  input  logic [11:0]   Nfft,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic [11:0]   est_STO,
  input  logic          est_done,
  output logic          out_valid,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_first,
  output logic [7:0]    out_sym,
  output logic          busy,
  output logic          ovf
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_EST, RUN} state_t;

  state_t          state, state_nxt;
  logic [11:0]     ng_q, nfft_q, smp;
  logic [7:0]      sym;
  logic [IW-1:0]   wr_idx, rd_idx, rd_base, fill;
  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_addr;
  logic            go_start, wr_req, full, wr_en;
  logic            rd_issue, smp_last, sym_last, frame_last;

  // A write would overwrite unread data only when it is a full buffer ahead of the read base;
  // a read base beyond the write index (estimate ahead of the data) never counts as overflow.
  assign go_start   = (state == IDLE) && go;
  assign wr_req     = (state != IDLE) && in_valid;
  assign rd_base    = (state == RUN) ? rd_idx : '0;
  assign fill       = wr_idx - rd_base;
  assign full       = (wr_idx >= rd_base) && ({1'b0, fill} >= DEPTH_W);
  assign wr_en      = go_start ? in_valid : (wr_req && !full);
  assign wr_addr    = go_start ? '0 : wr_idx[AW-1:0];
  assign rd_issue   = (state == RUN) && (rd_idx < wr_idx);
  assign smp_last   = (smp == nfft_q - 12'd1);
  assign sym_last   = (sym == 8'(NSYM - 1));
  assign frame_last = rd_issue && smp_last && sym_last;
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses <= so every flop updates from pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: frame start, estimate arrival, last sample issued.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:     if (go)         state_nxt = WAIT_EST;
      WAIT_EST: if (est_done)   state_nxt = RUN;
      RUN:      if (frame_last) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Sample buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; reads are guarded by rd_idx < wr_idx, so stale contents never escape.
    if (wr_en) mem[wr_addr] <= {in_re, in_im};
  end

  // Frame configuration, write index and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ng_q   <= '0;
      nfft_q <= '0;
      wr_idx <= '0;
      ovf    <= 1'b0;
    end else if (go_start) begin
      ng_q   <= Ng;
      nfft_q <= Nfft;
      ovf    <= 1'b0;
      wr_idx <= in_valid ? IW'(1) : '0;
    end else if (wr_req) begin
      if (full) ovf    <= 1'b1;
      else      wr_idx <= wr_idx + IW'(1);
    end
  end

  // Read pointer, in-symbol sample counter and symbol counter; skips Ng after each symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx <= '0;
      smp    <= '0;
      sym    <= '0;
    end else if (state == WAIT_EST && est_done) begin
      rd_idx <= IW'(est_STO) + IW'(ng_q);
      smp    <= '0;
      sym    <= '0;
    end else if (rd_issue) begin
      if (smp_last) begin
        smp    <= '0;
        sym    <= sym + 8'd1;
        rd_idx <= rd_idx + IW'(1) + IW'(ng_q);
      end else begin
        smp    <= smp + 12'd1;
        rd_idx <= rd_idx + IW'(1);
      end
    end
  end

  // Registered output stage; data and tags are zero whenever out_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_sym   <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= rd_issue;
      out_first <= rd_issue && (smp == '0);
      out_sym   <= rd_issue ? sym : '0;
      if (rd_issue) {out_re, out_im} <= mem[rd_idx[AW-1:0]];
      else          {out_re, out_im} <= '0;
    end
  end

endmodule

// File: tb/tb_sto_cp_remover.sv
// Bench for sto_cp_remover: stimulus pushes the expected symbol sample sequence into a queue when
// the estimate is delivered; a negedge monitor pops and checks data, tags, busy and issue timing.
module tb_sto_cp_remover;

  localparam int DW = 16, AW = 10, IW = 16, NSYM = 4;
  localparam int DEPTH = 1 << AW;
  localparam int MAXS  = 4096;

  logic          clk = 1'b0, reset = 1'b0, go = 1'b0, in_valid = 1'b0, est_done = 1'b0;
  logic [11:0]   Ng = '0, Nfft = '0, est_STO = '0;
  logic [DW-1:0] in_re = '0, in_im = '0;
  logic          out_valid, out_first, busy, ovf;
  logic [DW-1:0] out_re, out_im;
  logic [7:0]    out_sym;

  sto_cp_remover #(.DW(DW), .AW(AW), .IW(IW), .NSYM(NSYM)) dut (
    .clk(clk), .reset(reset), .go(go), .Ng(Ng), .Nfft(Nfft),
    .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .est_STO(est_STO), .est_done(est_done),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_first(out_first), .out_sym(out_sym), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Reference model: samples stored in this frame, by absolute index, and the edge each was written on.
  typedef struct { int idx; bit first; int sym; } exp_t;
  exp_t            sb[$];
  logic [2*DW-1:0] smp_val  [MAXS];
  int              smp_edge [MAXS];
  int              n_stored, est_edge, prev_l;
  bit              est_seen, ovf_exp;

  // Monitor: each output must be the next expected sample, issued as early as the data, the
  // estimate and the one-sample-per-cycle rate allow.
  exp_t me;
  int   lexp;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got out_re %0h with nothing expected (cycle %0d)", out_re, cyc);
        end else begin
          me = sb.pop_front();
          if (me.idx >= n_stored) begin
            checks++; errors++;
            $display("FAIL out_early: got sample index %0d before it was written (stored %0d)", me.idx, n_stored);
          end else begin
            lexp = max3(est_edge + 1, smp_edge[me.idx] + 1, prev_l + 1);
            check("out_time",  cyc, lexp);
            check("out_data",  {out_re, out_im}, smp_val[me.idx]);
            check("out_first", out_first, me.first);
            check("out_sym",   out_sym, me.sym);
            check("busy_at_out", busy, sb.size() != 0);
          end
          prev_l = cyc;
        end
      end else begin
        check("idle_zero", {out_first, out_sym, out_re, out_im}, '0);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      go       = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_re    = DW'($urandom);
      in_im    = DW'($urandom);
      est_done = ($urandom_range(0, 3) == 0);
      est_STO  = 12'($urandom);
      Ng       = 12'($urandom);
      Nfft     = 12'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // One frame: go at k=0, est_done at k=est_at, optional stray go/est_done, optional mid-run reset.
  task automatic run_frame(input int ng, input int nfft, input int sto, input int est_at,
                           input int vmode, input bit ramp, input int go2_at, input int rst_at);
    int k, n_off, e;
    bit done, aborted, v;
    logic [DW-1:0] re, im;
    k = 0; n_off = 0; done = 0; aborted = 0;
    n_stored = 0; est_seen = 0; ovf_exp = 0; prev_l = 0; est_edge = 0;
    while (!done) begin
      go       = (k == 0) || (k == go2_at);
      Ng       = (k == 0) ? 12'(ng)   : 12'($urandom);
      Nfft     = (k == 0) ? 12'(nfft) : 12'($urandom);
      est_done = (k == est_at) || (go2_at >= 0 && k == go2_at + 50);
      est_STO  = (k == est_at) ? 12'(sto) : 12'($urandom);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      re = ramp ? DW'(n_off)  : DW'($urandom);
      im = ramp ? DW'(-n_off) : DW'($urandom);
      in_valid = v; in_re = re; in_im = im;
      @(posedge clk); #1;
      e = cyc;
      if (v) begin
        if (!est_seen && n_stored >= DEPTH) ovf_exp = 1'b1;
        else if (n_stored < MAXS) begin
          smp_val[n_stored]  = {re, im};
          smp_edge[n_stored] = e;
          n_stored++;
        end
        n_off++;
      end
      if (k == 0) begin
        check("busy_after_go", busy, 1'b1);
        check("ovf_after_go",  ovf,  1'b0);
      end
      if (k == est_at) begin
        est_seen = 1'b1;
        est_edge = e;
        for (int s = 0; s < NSYM; s++)
          for (int j = 0; j < nfft; j++)
            sb.push_back('{sto + ng + s * (nfft + ng) + j, (j == 0), s});
      end
      if (k == rst_at) begin
        check("ovf_before_reset",       ovf,       ovf_exp);
        check("busy_before_reset",      busy,      1'b1);
        check("out_valid_before_reset", out_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_ovf",       ovf,       1'b0);
        check("rst_out_sym",   out_sym,   8'd0);
        sb.delete();
        go = 1'b0; in_valid = 1'b0; est_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        done = 1'b1; aborted = 1'b1;
      end
      k++;
      if (!done && est_seen && sb.size() == 0) done = 1'b1;
      if (!done && k > 6000) begin
        checks++; errors++;
        $display("FAIL frame_timeout: got %0d samples outstanding after %0d cycles, expected 0", sb.size(), k);
        sb.delete();
        done = 1'b1;
      end
    end
    if (!aborted) begin
      go = 1'b0; in_valid = 1'b0; est_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("ovf_end",       ovf,       ovf_exp);
      check("busy_end",      busy,      1'b0);
      check("out_valid_end", out_valid, 1'b0);
    end
  endtask

  initial begin
    #12;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy",      busy,      1'b0);
    check("reset_ovf",       ovf,       1'b0);
    check("reset_out_sym",   out_sym,   8'd0);
    check("reset_data",      {out_first, out_re, out_im}, '0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    idle(5);
    // ramp, estimate arrives late: burst from index 64, symbol starts 64,224,384,544
    run_frame(32, 128, 32, 300, 0, 1'b1, -1, -1);
    idle(4);
    // estimate early, input every other cycle: output paced by input
    run_frame(32, 128, 32, 5, 1, 1'b1, -1, -1);
    idle(4);
    // zero STO, short symbols: starts at 16,96,176,256
    run_frame(16, 64, 0, 50, 0, 1'b1, -1, -1);
    idle(4);
    // estimate after more than a buffer of samples: overflow, later samples dropped
    run_frame(32, 128, 32, 1100, 0, 1'b1, -1, -1);
    idle(4);
    // stray go and est_done during RUN are ignored (also shows the new go cleared ovf)
    run_frame(32, 128, 32, 300, 0, 1'b1, 400, -1);
    idle(4);
    // reset asserted mid-RUN of an overflowed frame, then a clean restart
    run_frame(32, 128, 32, 1100, 0, 1'b1, -1, 1400);
    idle(4);
    run_frame(32, 128, 32, 300, 0, 1'b1, -1, -1);
    // randomized frames
    for (int f = 0; f < 6; f++) begin
      idle($urandom_range(2, 10));
      run_frame($urandom_range(0, 64), $urandom_range(16, 128), $urandom_range(0, 200),
                $urandom_range(1, 400), 2, 1'b0, -1, -1);
    end
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion after 500000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
